// File: rtl/audio_pkg.sv
// audio_pkg: shared widths, FSM states and saturating helpers for the audio demux receiver.
package audio_pkg;
   localparam int SAMPLE_W = 12;
   localparam int PHASE_W = 32;

   typedef enum logic [1:0] {ACC, ENV, OUT} state_t;

   typedef struct packed {
      logic sat;
      logic signed [SAMPLE_W-1:0] val;
   } sat_t;

   function automatic sat_t sat12(input logic signed [31:0] v);
      sat_t r;
      r.sat = v > 32'sd2047 || v < -32'sd2048;
      r.val = v > 32'sd2047 ? 12'h7ff : v < -32'sd2048 ? 12'h800 : v[11:0];
      return r;
   endfunction

   // Negation whose only overflow case (-2048) clamps to +2047
   function automatic sat_t neg12(input logic signed [SAMPLE_W-1:0] x);
      sat_t r;
      r.sat = x == {1'b1, {(SAMPLE_W-1){1'b0}}};
      r.val = r.sat ? {1'b0, {(SAMPLE_W-1){1'b1}}} : -x;
      return r;
   endfunction
endpackage

// File: rtl/iq_envelope.sv
// iq_envelope: window-mean scaling, |I|/|Q| and max+min/2 magnitude estimate, registered.
module iq_envelope
   import audio_pkg::*;
#(
   parameter int AVG_LOG2 = 6,
   parameter int ACC_W = SAMPLE_W + AVG_LOG2
) (
   input  logic                       clk_in,
   input  logic                       RST,
   input  logic                       en,
   input  logic signed [ACC_W-1:0]    a1,
   input  logic signed [ACC_W-1:0]    ai,
   input  logic signed [ACC_W-1:0]    aq,
   output logic signed [SAMPLE_W-1:0] ch1,
   output logic        [SAMPLE_W:0]   env
);
   logic [SAMPLE_W-1:0] i_m, q_m, mx, mn;

   // A window mean of -2048 negates to 2048, which still fits the unsigned magnitude
   assign i_m = ai[ACC_W-1] ? SAMPLE_W'(-(ai >>> AVG_LOG2)) : SAMPLE_W'(ai >>> AVG_LOG2);
   assign q_m = aq[ACC_W-1] ? SAMPLE_W'(-(aq >>> AVG_LOG2)) : SAMPLE_W'(aq >>> AVG_LOG2);
   assign mx = i_m > q_m ? i_m : q_m;
   assign mn = i_m > q_m ? q_m : i_m;

   always_ff @(posedge clk_in or negedge RST) begin
      if (!RST) begin
         ch1 <= '0;
         env <= '0;
      end else if (en) begin
         ch1 <= SAMPLE_W'(a1 >>> AVG_LOG2);
         env <= {1'b0, mx} + (SAMPLE_W+1)'(mn >> 1);
      end
   end
endmodule

// File: rtl/audio_demux_rx.sv
// audio_demux_rx: recovers baseband CH1 and AM subcarrier CH2 from FM-demodulated composite samples
// via integrate-and-dump, square-wave I/Q mixing, envelope detection and IIR carrier removal.
module audio_demux_rx
   import audio_pkg::*;
#(
   parameter logic [PHASE_W-1:0] FRE_WORD = 32'd268435456,
   parameter int AVG_LOG2 = 6,
   parameter int DC_SHIFT = 8
) (
   input  logic                       clk_in,
   input  logic                       RST,
   input  logic signed [SAMPLE_W-1:0] demod_in,
   input  logic                       demod_valid,
   output logic signed [SAMPLE_W-1:0] Audio_CH1,
   output logic signed [SAMPLE_W-1:0] Audio_CH2,
   output logic                       ch_valid,
   output logic                       sat_flag
);
   localparam int ACC_W = SAMPLE_W + AVG_LOG2;
   localparam int DC_W = SAMPLE_W + 1 + DC_SHIFT;

   state_t state, state_nxt;
   logic [PHASE_W-1:0] phase;
   logic [AVG_LOG2-1:0] cnt;
   logic dump;
   logic signed [ACC_W-1:0] a1, ai, aq, a1_nxt, ai_nxt, aq_nxt, d1, di, dq;
   sat_t neg, mix_i, mix_q, ch2_s;
   logic signed [SAMPLE_W-1:0] ch1;
   logic [SAMPLE_W:0] env;
   logic [DC_W-1:0] dc;
   logic signed [DC_W:0] dc_diff, dc_step;
   logic signed [SAMPLE_W+1:0] ch2_d;

   assign neg = neg12(demod_in);
   assign mix_i = phase[PHASE_W-1] ? neg : sat_t'({1'b0, demod_in});
   assign mix_q = (phase[PHASE_W-1] ^ phase[PHASE_W-2]) ? neg : sat_t'({1'b0, demod_in});
   assign a1_nxt = (cnt == '0 ? '0 : a1) + ACC_W'(demod_in);
   assign ai_nxt = (cnt == '0 ? '0 : ai) + ACC_W'($signed(mix_i.val));
   assign aq_nxt = (cnt == '0 ? '0 : aq) + ACC_W'($signed(mix_q.val));

   always_ff @(posedge clk_in or negedge RST) begin
      if (!RST) begin
         phase <= '0;
         cnt <= '0;
         dump <= 1'b0;
         a1 <= '0;
         ai <= '0;
         aq <= '0;
         d1 <= '0;
         di <= '0;
         dq <= '0;
      end else begin
         dump <= demod_valid && cnt == '1;
         if (demod_valid) begin
            phase <= phase + FRE_WORD;
            cnt <= cnt + 1'b1;
            a1 <= a1_nxt;
            ai <= ai_nxt;
            aq <= aq_nxt;
            if (cnt == '1) begin
               d1 <= a1_nxt;
               di <= ai_nxt;
               dq <= aq_nxt;
            end
         end
      end
   end

   always_ff @(posedge clk_in or negedge RST) begin
      if (!RST) state <= ACC;
      else state <= state_nxt;
   end

   always_comb begin
      state_nxt = state == ACC ? (dump ? ENV : ACC) : state == ENV ? OUT : ACC;
   end

   iq_envelope #(.AVG_LOG2(AVG_LOG2), .ACC_W(ACC_W)) u_env (
      .clk_in(clk_in),
      .RST(RST),
      .en(state == ENV),
      .a1(d1),
      .ai(di),
      .aq(dq),
      .ch1(ch1),
      .env(env)
   );

   // dc carries DC_SHIFT fractional bits; CH2 subtracts its integer part before the update
   assign dc_diff = $signed({1'b0, env, {DC_SHIFT{1'b0}}}) - $signed({1'b0, dc});
   assign dc_step = dc_diff >>> DC_SHIFT;
   assign ch2_d = $signed({1'b0, env}) - $signed({1'b0, dc[DC_W-1:DC_SHIFT]});
   assign ch2_s = sat12(32'(ch2_d));

   always_ff @(posedge clk_in or negedge RST) begin
      if (!RST) begin
         Audio_CH1 <= '0;
         Audio_CH2 <= '0;
         ch_valid <= 1'b0;
         sat_flag <= 1'b0;
         dc <= '0;
      end else begin
         ch_valid <= state == OUT;
         sat_flag <= sat_flag | (demod_valid & (mix_i.sat | mix_q.sat)) | (state == OUT & ch2_s.sat);
         if (state == OUT) begin
            Audio_CH1 <= ch1;
            Audio_CH2 <= ch2_s.val;
            dc <= DC_W'($signed({1'b0, dc}) + dc_step);
         end
      end
   end

   // A window is at least 4 samples long, so a dump can never overlap ENV/OUT
   assert property (@(posedge clk_in) disable iff (!RST) dump |-> state == ACC);
endmodule

// File: tb/tb_audio_demux_rx.sv
// tb_audio_demux_rx: randomized stimulus against a window-level behavioural model of the receiver.
module tb_audio_demux_rx;
   localparam bit [31:0] FW = 32'd268435456;

   logic clk_in = 1'b0;
   logic RST = 1'b0;
   logic signed [11:0] demod_in = '0;
   logic demod_valid = 1'b0;
   logic signed [11:0] Audio_CH1, Audio_CH2;
   logic ch_valid, sat_flag;

   int checks = 0, errors = 0;

   always #5 clk_in = ~clk_in;

   audio_demux_rx dut (
      .clk_in(clk_in),
      .RST(RST),
      .demod_in(demod_in),
      .demod_valid(demod_valid),
      .Audio_CH1(Audio_CH1),
      .Audio_CH2(Audio_CH2),
      .ch_valid(ch_valid),
      .sat_flag(sat_flag)
   );

   // stimulus generator: mode 0 constant, 1 carrier-aligned square, 2 random
   int mode = 0, amp = 0, mode_req = 0, amp_req = 1000, duty = 100;
   int gen_k = 0, smp;
   bit [31:0] gen_ph;
   bit v;

   always @(posedge clk_in) begin
      #2;
      if (!RST) gen_k = 0;
      if (gen_k % 64 == 0) begin
         mode = mode_req;
         amp = amp_req;
      end
      v = RST && ($urandom_range(99) < duty);
      gen_ph = FW * gen_k;
      smp = mode == 0 ? amp : mode == 1 ? (gen_ph[31] ? -amp : amp) : int'($urandom_range(4095)) - 2048;
      demod_valid = v;
      demod_in = v ? 12'(smp) : 12'($urandom);
      if (v) gen_k++;
   end

   // behavioural model: windows of 64 accepted samples, results due 3 edges after the last one
   typedef struct {
      longint due;
      int ch1;
      int ch2;
      bit sat;
   } win_t;
   win_t pend[$];
   win_t w;
   longint cyc, m_k, s1, si, sq, m_dc, iv, qv, mx, mn, envv, ch2v;
   int nacc, x, xi, xq, m_ch1, m_ch2;
   bit m_valid, m_sat;
   bit [31:0] lo;

   always @(posedge clk_in or negedge RST) begin
      if (!RST) begin
         cyc = 0; m_k = 0; nacc = 0; s1 = 0; si = 0; sq = 0; m_dc = 0;
         m_ch1 = 0; m_ch2 = 0; m_valid = 0; m_sat = 0;
         pend.delete();
      end else begin
         cyc++;
         m_valid = 0;
         if (pend.size() > 0 && pend[0].due == cyc) begin
            w = pend.pop_front();
            m_ch1 = w.ch1;
            m_ch2 = w.ch2;
            m_valid = 1;
            m_sat |= w.sat;
         end
         if (demod_valid) begin
            lo = FW * m_k[31:0];
            x = demod_in;
            xi = lo[31] ? -x : x;
            xq = (lo[31] ^ lo[30]) ? -x : x;
            if (xi > 2047) begin xi = 2047; m_sat = 1; end
            if (xq > 2047) begin xq = 2047; m_sat = 1; end
            s1 += x; si += xi; sq += xq;
            m_k++; nacc++;
            if (nacc == 64) begin
               iv = si >>> 6; if (iv < 0) iv = -iv;
               qv = sq >>> 6; if (qv < 0) qv = -qv;
               mx = iv > qv ? iv : qv;
               mn = iv > qv ? qv : iv;
               envv = mx + (mn >> 1);
               ch2v = envv - (m_dc >>> 8);
               w.sat = ch2v > 2047 || ch2v < -2048;
               w.ch2 = ch2v > 2047 ? 2047 : ch2v < -2048 ? -2048 : int'(ch2v);
               w.ch1 = int'(s1 >>> 6);
               w.due = cyc + 3;
               m_dc = m_dc + (((envv << 8) - m_dc) >>> 8);
               pend.push_back(w);
               nacc = 0; s1 = 0; si = 0; sq = 0;
            end
         end
      end
   end

   always @(negedge clk_in) begin
      checks++;
      if (Audio_CH1 !== 12'(m_ch1) || Audio_CH2 !== 12'(m_ch2) || ch_valid !== m_valid || sat_flag !== m_sat) begin
         errors++;
         $display("FAIL outputs t=%0t: got ch1=%0d ch2=%0d valid=%b sat=%b, expected ch1=%0d ch2=%0d valid=%b sat=%b",
                  $time, Audio_CH1, Audio_CH2, ch_valid, sat_flag, m_ch1, m_ch2, m_valid, m_sat);
      end
   end

   // window capture for hand-computed checks
   longint tb_cyc = 0, last_vcyc = 0, last_gap = 0;
   int win_cnt = 0, last_ch1 = 0, last_ch2 = 0;

   always @(posedge clk_in) tb_cyc++;

   always @(negedge clk_in) begin
      if (ch_valid === 1'b1) begin
         last_gap = tb_cyc - last_vcyc;
         last_vcyc = tb_cyc;
         last_ch1 = Audio_CH1;
         last_ch2 = Audio_CH2;
         win_cnt++;
      end
   end

   task automatic chk(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic wait_win(input int n, input int budget);
      int target, t;
      target = win_cnt + n;
      t = 0;
      while (win_cnt < target && t < budget) begin
         @(negedge clk_in);
         #1;
         t++;
      end
      checks++;
      if (win_cnt < target) begin
         errors++;
         $display("FAIL wait_win: got %0d windows, expected %0d within %0d cycles", win_cnt, target, budget);
      end
   endtask

   task automatic do_reset_pulse();
      @(posedge clk_in);
      #3 RST = 1'b0;
      #1;
      chk("async_rst_ch1", Audio_CH1, 0);
      chk("async_rst_ch2", Audio_CH2, 0);
      chk("async_rst_valid", ch_valid, 0);
      chk("async_rst_sat", sat_flag, 0);
      repeat (2) @(posedge clk_in);
   endtask

   longint rel, pre;

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      mode_req = 0; amp_req = 1000; duty = 100;
      repeat (3) @(posedge clk_in);
      #1;
      chk("reset_ch1", Audio_CH1, 0);
      chk("reset_sat", sat_flag, 0);
      #2 RST = 1'b1;
      // DC input: whole LO periods cancel, so only CH1 carries the level
      wait_win(4, 400);
      chk("dc_ch1", last_ch1, 1000);
      chk("dc_ch2", last_ch2, 0);
      chk("dc_gap", last_gap, 64);
      // reset mid-window, then carrier-aligned square
      repeat (30) @(posedge clk_in);
      mode_req = 1; amp_req = 800;
      do_reset_pulse();
      #3 RST = 1'b1;
      rel = tb_cyc;
      wait_win(1, 200);
      chk("first_valid_latency", last_vcyc - rel, 68);
      chk("sq_w1_ch1", last_ch1, 0);
      chk("sq_w1_ch2", last_ch2, 800);
      wait_win(1, 200);
      chk("sq_w2_ch2", last_ch2, 797);
      wait_win(1, 200);
      chk("sq_w3_ch2", last_ch2, 794);
      wait_win(150, 150 * 70);
      // AM step 800 -> 1200 on a window boundary
      amp_req = 1200;
      wait_win(1, 200);
      pre = last_ch2;
      wait_win(1, 200);
      checks++;
      if (last_ch2 - pre < 390 || last_ch2 - pre > 400) begin
         errors++;
         $display("FAIL am_step: got jump %0d, expected 390..400", last_ch2 - pre);
      end
      chk("am_step_ch1", last_ch1, 0);
      // stalls at 30% duty: same window values, stretched in time
      amp_req = 800; duty = 30;
      do_reset_pulse();
      #3 RST = 1'b1;
      wait_win(1, 1500);
      chk("stall_w1_ch2", last_ch2, 800);
      wait_win(1, 1500);
      chk("stall_w2_ch2", last_ch2, 797);
      chk("stall_w2_ch1", last_ch1, 0);
      wait_win(6, 6 * 1500);
      // random samples with random valid
      mode_req = 2; duty = 70;
      wait_win(10, 10 * 400);
      // saturation on negating -2048
      mode_req = 0; amp_req = -2048; duty = 100;
      do_reset_pulse();
      #3 RST = 1'b1;
      repeat (4) @(posedge clk_in);
      #1 chk("sat_before_neg", sat_flag, 0);
      repeat (20) @(posedge clk_in);
      #1 chk("sat_set", sat_flag, 1);
      wait_win(2, 300);
      chk("sat_ch1", last_ch1, -2048);
      chk("sat_sticky", sat_flag, 1);
      do_reset_pulse();
      #3 RST = 1'b1;
      repeat (5) @(posedge clk_in);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
